// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86 icode/stat encodings and the pipeline run-state type
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] S_BUB = 4'h0;
   localparam logic [3:0] S_AOK = 4'h1;
   localparam logic [3:0] S_HLT = 4'h2;
   localparam logic [3:0] S_ADR = 4'h3;
   localparam logic [3:0] S_INS = 4'h4;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PAUSE  = 2'd1,
      HALTED = 2'd2,
      FAULT  = 2'd3
   } run_state_e;

   // Bubble status (0) counts as healthy, so only HLT/ADR/INS terminate.
   function automatic logic is_exc(input logic [3:0] stat);
      return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational hazard terms from decode and E/M/W stage fields
module hazard_detect
   import y86_pkg::*;
(
   input  logic [3:0] D_icode,
   input  logic [3:0] d_srcA,
   input  logic [3:0] d_srcB,
   input  logic [3:0] E_icode,
   input  logic [3:0] E_destM,
   input  logic       e_Cnd,
   input  logic [3:0] M_icode,
   input  logic [3:0] m_stat,
   input  logic [3:0] W_stat,
   output logic       loaduse,
   output logic       retp,
   output logic       mispred,
   output logic       mexc,
   output logic       wexc
);

   logic e_is_load;

   assign e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);

   assign loaduse = e_is_load && (E_destM != REG_NONE) &&
                    ((E_destM == d_srcA) || (E_destM == d_srcB));
   assign retp    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
   assign mispred = (E_icode == I_JXX) && !e_Cnd;
   assign mexc    = is_exc(m_stat);
   assign wexc    = is_exc(W_stat);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86 pipeline stall/bubble control, run-state FSM, hazard counters
// Optional counters: define PIPE_CTRL_PERF_CNT_EN to build them, otherwise they read 0.
module pipe_ctrl
   import y86_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             run_en,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_destM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic [3:0]       m_stat,
   input  logic [3:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             set_cc,
   output logic             cpu_halted,
   output logic [3:0]       exc_code,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] mp_cnt,
   output logic [CNT_W-1:0] ret_cnt
);

   logic       loaduse, retp, mispred, mexc, wexc;
   logic       active;
   run_state_e state_q;
   logic       cpu_halted_q;
   logic [3:0] exc_code_q;

   hazard_detect u_hazard_detect (
      .D_icode (D_icode),
      .d_srcA  (d_srcA),
      .d_srcB  (d_srcB),
      .E_icode (E_icode),
      .E_destM (E_destM),
      .e_Cnd   (e_Cnd),
      .M_icode (M_icode),
      .m_stat  (m_stat),
      .W_stat  (W_stat),
      .loaduse (loaduse),
      .retp    (retp),
      .mispred (mispred),
      .mexc    (mexc),
      .wexc    (wexc)
   );

   assign active = (state_q == RUN) && run_en;

   // A terminating W status wins over a pause request on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         cpu_halted_q <= 1'b0;
         exc_code_q   <= 4'h0;
      end else begin
         case (state_q)
            RUN: begin
               if (wexc) begin
                  state_q      <= (W_stat == S_HLT) ? HALTED : FAULT;
                  cpu_halted_q <= 1'b1;
                  exc_code_q   <= W_stat;
               end else if (!run_en) begin
                  state_q <= PAUSE;
               end
            end
            PAUSE: begin
               if (run_en) state_q <= RUN;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      set_cc   = 1'b0;
      if (active) begin
         F_stall  = loaduse | retp;
         D_stall  = loaduse;
         D_bubble = mispred | (retp & !loaduse);
         E_bubble = mispred | loaduse;
         M_bubble = mexc | wexc;
         W_stall  = wexc;
         set_cc   = (E_icode == I_OPQ) & !mexc & !wexc;
      end
   end

   assign cpu_halted = cpu_halted_q;
   assign exc_code   = exc_code_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, lu_cnt_q, mp_cnt_q, ret_cnt_q;
   logic [CNT_W-1:0] cycle_cnt_d, lu_cnt_d, mp_cnt_d, ret_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      lu_cnt_d    = lu_cnt_q;
      mp_cnt_d    = mp_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      if (active) begin
         cycle_cnt_d = sat_inc(cycle_cnt_q);
         if (loaduse)          lu_cnt_d  = sat_inc(lu_cnt_q);
         if (mispred)          mp_cnt_d  = sat_inc(mp_cnt_q);
         if (retp && !loaduse) ret_cnt_d = sat_inc(ret_cnt_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         lu_cnt_q    <= '0;
         mp_cnt_q    <= '0;
         ret_cnt_q   <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         lu_cnt_q    <= lu_cnt_d;
         mp_cnt_q    <= mp_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign lu_cnt    = lu_cnt_q;
   assign mp_cnt    = mp_cnt_q;
   assign ret_cnt   = ret_cnt_q;
`else
   assign cycle_cnt = '0;
   assign lu_cnt    = '0;
   assign mp_cnt    = '0;
   assign ret_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed plus randomized checks of pipe_ctrl against a rule-level model
module tb_pipe_ctrl;

   localparam int W   = 4;
   localparam int SAT = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         run_en;
   logic [3:0]   D_icode, d_srcA, d_srcB, E_icode, E_destM, M_icode, m_stat, W_stat;
   logic         e_Cnd;
   logic         F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, cpu_halted;
   logic [3:0]   exc_code;
   logic [W-1:0] cycle_cnt, lu_cnt, mp_cnt, ret_cnt;

   int checks = 0;
   int errors = 0;

   bit         m_stopped, m_paused;
   logic [3:0] m_exc;
   int         m_cyc, m_lu, m_mp, m_ret;

   pipe_ctrl #(.CNT_W(W)) dut (
      .clk(clk), .rst(rst), .run_en(run_en),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_destM(E_destM), .e_Cnd(e_Cnd),
      .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
      .set_cc(set_cc), .cpu_halted(cpu_halted), .exc_code(exc_code),
      .cycle_cnt(cycle_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_term(input logic [3:0] s);
      return (s >= 4'd2) && (s <= 4'd4);
   endfunction

   function automatic bit h_lu();
      return ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_destM != 4'hF) &&
             ((E_destM == d_srcA) || (E_destM == d_srcB));
   endfunction

   function automatic bit h_ret();
      return (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
   endfunction

   function automatic bit h_mp();
      return (E_icode == 4'h7) && !e_Cnd;
   endfunction

   task automatic model_reset();
      m_stopped = 0; m_paused = 0; m_exc = 4'h0;
      m_cyc = 0; m_lu = 0; m_mp = 0; m_ret = 0;
   endtask

   function automatic int sat(input int v);
      return (v >= SAT) ? SAT : v + 1;
   endfunction

   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else if (m_stopped) begin
      end else if (m_paused) begin
         if (run_en) m_paused = 0;
      end else begin
         if (run_en) begin
            m_cyc = sat(m_cyc);
            if (h_lu())             m_lu  = sat(m_lu);
            if (h_mp())             m_mp  = sat(m_mp);
            if (h_ret() && !h_lu()) m_ret = sat(m_ret);
         end
         if (is_term(W_stat)) begin
            m_stopped = 1;
            m_exc     = W_stat;
         end else if (!run_en) begin
            m_paused = 1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      bit lu, rp, mp, mx, wx, act;
      int e_cyc, e_lu, e_mp, e_ret;
      lu  = h_lu();
      rp  = h_ret();
      mp  = h_mp();
      mx  = is_term(m_stat);
      wx  = is_term(W_stat);
      act = !m_stopped && !m_paused && run_en;
`ifdef PIPE_CTRL_PERF_CNT_EN
      e_cyc = m_cyc; e_lu = m_lu; e_mp = m_mp; e_ret = m_ret;
`else
      e_cyc = 0; e_lu = 0; e_mp = 0; e_ret = 0;
`endif
      chk({tag, ".F_stall"},  32'(F_stall),  act ? 32'(lu | rp) : 32'd1);
      chk({tag, ".D_stall"},  32'(D_stall),  act ? 32'(lu) : 32'd1);
      chk({tag, ".D_bubble"}, 32'(D_bubble), act ? 32'(mp | (rp & !lu)) : 32'd0);
      chk({tag, ".E_bubble"}, 32'(E_bubble), act ? 32'(mp | lu) : 32'd1);
      chk({tag, ".M_bubble"}, 32'(M_bubble), act ? 32'(mx | wx) : 32'd1);
      chk({tag, ".W_stall"},  32'(W_stall),  act ? 32'(wx) : 32'd1);
      chk({tag, ".set_cc"},   32'(set_cc),   act ? 32'((E_icode == 4'h6) & !mx & !wx) : 32'd0);
      chk({tag, ".cpu_halted"}, 32'(cpu_halted), 32'(m_stopped));
      chk({tag, ".exc_code"}, 32'(exc_code), 32'(m_exc));
      chk({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(e_cyc));
      chk({tag, ".lu_cnt"},   32'(lu_cnt),   32'(e_lu));
      chk({tag, ".mp_cnt"},   32'(mp_cnt),   32'(e_mp));
      chk({tag, ".ret_cnt"},  32'(ret_cnt),  32'(e_ret));
   endtask

   task automatic idle();
      run_en = 1'b1;
      D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
      E_icode = 4'h1; E_destM = 4'hF; e_Cnd = 1'b0;
      M_icode = 4'h1; m_stat = 4'h1; W_stat = 4'h1;
   endtask

   task automatic randomize_inputs();
      int r;
      run_en  = ($urandom_range(0, 9) < 8);
      D_icode = 4'($urandom_range(0, 11));
      d_srcA  = 4'($urandom_range(0, 15));
      d_srcB  = 4'($urandom_range(0, 15));
      E_icode = 4'($urandom_range(0, 11));
      E_destM = 4'($urandom_range(0, 15));
      e_Cnd   = 1'($urandom_range(0, 1));
      M_icode = 4'($urandom_range(0, 11));
      m_stat  = ($urandom_range(0, 9) < 2) ? 4'($urandom_range(2, 4)) : 4'($urandom_range(0, 1));
      r       = $urandom_range(0, 99);
      W_stat  = (r < 3) ? 4'($urandom_range(2, 4)) : 4'($urandom_range(0, 1));
   endtask

   // Check just after inputs settle, then let the edge happen and advance the model.
   task automatic step(input string tag);
      #2;
      check_all(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      model_reset();
      #2;
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      #3;
      check_all("reset");
      randomize_inputs();
      #1;
      check_all("reset_rand");
      idle();
      @(negedge clk);
      rst = 1'b0;

      step("idle");

      E_icode = 4'h5; E_destM = 4'h3; d_srcB = 4'h3;
      step("loaduse");
      idle();
      E_icode = 4'hB; E_destM = 4'hF; d_srcA = 4'hF;
      step("popq_none");

      idle(); D_icode = 4'h9;
      step("ret_d");
      idle(); E_icode = 4'h9;
      step("ret_e");
      idle(); M_icode = 4'h9;
      step("ret_m");
      idle();
      step("ret_done");

      E_icode = 4'h5; E_destM = 4'h2; d_srcA = 4'h2; D_icode = 4'h9;
      step("lu_ret");
      idle(); E_icode = 4'h7; e_Cnd = 1'b0;
      step("mispred");
      e_Cnd = 1'b1;
      step("taken");
      idle(); E_icode = 4'h6;
      step("opq");

      idle(); run_en = 1'b0;
      for (int i = 0; i < 4; i++) step("pause");
      W_stat = 4'h3;
      step("pause_wstat");
      idle();
      step("resume");
      step("resumed");

      E_icode = 4'h6; m_stat = 4'h3;
      step("mexc");
      idle(); W_stat = 4'h3;
      step("wexc_adr");
      for (int i = 0; i < 10; i++) begin
         randomize_inputs();
         step("fault_hold");
      end
      do_reset("rst_fault");
      idle();
      step("post_rst");

      run_en = 1'b0; W_stat = 4'h2;
      step("hlt_vs_pause");
      idle();
      step("halted");
      do_reset("rst_halt");
      idle();

      for (int i = 0; i < 300; i++) begin
         if (m_stopped && ($urandom_range(0, 3) == 0)) begin
            do_reset("rand_rst");
         end
         randomize_inputs();
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
